// File: rtl/ref_line_sequencer.sv
// ref_line_sequencer: walks one reference-block fetch over its cache-line grid in raster order,
// emitting one registered line beat per downstream handshake.
// Optional macro REF_LINE_SEQ_BACK_TO_BACK_EN lets a new request be taken while the last beat
// of the current block is being accepted, so consecutive blocks stream without a bubble.
module ref_line_sequencer #(
    parameter int X_ADDR_WDTH   = 12,
    parameter int Y_ADDR_WDTH   = 12,
    parameter int C_L_H_SIZE    = 3,
    parameter int C_L_V_SIZE    = 3,
    parameter int LUMA_DIM_WDTH = 4,
    parameter int REF_ADDR_WDTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [X_ADDR_WDTH-1:0]        req_start_x,
    input  logic [Y_ADDR_WDTH-1:0]        req_start_y,
    input  logic [LUMA_DIM_WDTH-1:0]      req_wdt_m1,
    input  logic [LUMA_DIM_WDTH-1:0]      req_hgt_m1,
    input  logic [REF_ADDR_WDTH-1:0]      req_ref_idx,
    input  logic                          flush,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [X_ADDR_WDTH-C_L_H_SIZE-1:0] curr_x_addr,
    output logic [Y_ADDR_WDTH-C_L_V_SIZE-1:0] curr_y_addr,
    output logic [1:0]                    curr_x,
    output logic [1:0]                    curr_y,
    output logic [1:0]                    delta_x,
    output logic [1:0]                    delta_y,
    output logic [REF_ADDR_WDTH-1:0]      ref_idx_out,
    output logic                          first_line,
    output logic                          last_line,
    output logic                          busy
);
    localparam int XA  = X_ADDR_WDTH - C_L_H_SIZE;
    localparam int YA  = Y_ADDR_WDTH - C_L_V_SIZE;
    localparam int SXW = (LUMA_DIM_WDTH > C_L_H_SIZE ? LUMA_DIM_WDTH : C_L_H_SIZE) + 1;
    localparam int SYW = (LUMA_DIM_WDTH > C_L_V_SIZE ? LUMA_DIM_WDTH : C_L_V_SIZE) + 1;

    typedef enum logic {IDLE, WALK} state_t;

    state_t          state, state_nxt;
    logic [XA-1:0]   base_x;
    logic [YA-1:0]   base_y;
    logic [SXW-1:0]  sum_x;
    logic [SYW-1:0]  sum_y;
    logic [1:0]      dx_new, dy_new, nx, ny;
    logic            step_x, accept, beat;

    assign accept = req_valid && req_ready;
    assign beat   = out_valid && out_ready;

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state: flush wins, then a new request, then completion of the last beat
    always_comb begin
        state_nxt = state;
        if (flush)                                     state_nxt = IDLE;
        else if (accept)                               state_nxt = WALK;
        else if (state == WALK && beat && last_line)   state_nxt = IDLE;
    end

    // handshake and status outputs
    always_comb begin
        out_valid = state == WALK;
        busy      = state == WALK;
`ifdef REF_LINE_SEQ_BACK_TO_BACK_EN
        req_ready = !flush && (state == IDLE || (state == WALK && out_ready && last_line));
`else
        req_ready = !flush && state == IDLE;
`endif
    end

    // span of the incoming request and the raster step from the current line
    always_comb begin
        sum_x  = SXW'(req_start_x[C_L_H_SIZE-1:0]) + SXW'(req_wdt_m1);
        sum_y  = SYW'(req_start_y[C_L_V_SIZE-1:0]) + SYW'(req_hgt_m1);
        dx_new = 2'(sum_x >> C_L_H_SIZE);
        dy_new = 2'(sum_y >> C_L_V_SIZE);
        step_x = curr_x < delta_x;
        nx     = step_x ? curr_x + 2'd1 : 2'd0;
        ny     = step_x ? curr_y : curr_y + 2'd1;
    end

    // beat registers: load on acceptance, advance on each non-final handshake
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            base_x      <= '0;
            base_y      <= '0;
            curr_x_addr <= '0;
            curr_y_addr <= '0;
            curr_x      <= '0;
            curr_y      <= '0;
            delta_x     <= '0;
            delta_y     <= '0;
            ref_idx_out <= '0;
            first_line  <= 1'b0;
            last_line   <= 1'b0;
        end else if (accept) begin
            base_x      <= req_start_x[X_ADDR_WDTH-1:C_L_H_SIZE];
            base_y      <= req_start_y[Y_ADDR_WDTH-1:C_L_V_SIZE];
            curr_x_addr <= req_start_x[X_ADDR_WDTH-1:C_L_H_SIZE];
            curr_y_addr <= req_start_y[Y_ADDR_WDTH-1:C_L_V_SIZE];
            curr_x      <= '0;
            curr_y      <= '0;
            delta_x     <= dx_new;
            delta_y     <= dy_new;
            ref_idx_out <= req_ref_idx;
            first_line  <= 1'b1;
            last_line   <= dx_new == 2'd0 && dy_new == 2'd0;
        end else if (beat && !last_line) begin
            curr_x      <= nx;
            curr_y      <= ny;
            curr_x_addr <= base_x + XA'(nx);
            curr_y_addr <= base_y + YA'(ny);
            first_line  <= 1'b0;
            last_line   <= nx == delta_x && ny == delta_y;
        end
    end
endmodule
